// File: rtl/obi_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone master between the core's OBI
// instruction and data ports; one transaction in flight, with bus timeout.
module obi_wb_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk_core,
   input  logic                    rst_core,

   input  logic                    instr_req_i,
   input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
   output logic                    instr_gnt_o,
   output logic                    instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]   instr_rdata_o,
   output logic                    instr_err_o,

   input  logic                    data_req_i,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,
   output logic                    data_err_o,

   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   output logic [ADDR_WIDTH-1:0]   wb_addr_o,
   output logic [DATA_WIDTH-1:0]   wb_data_o,
   input  logic [DATA_WIDTH-1:0]   wb_data_i,
   input  logic                    wb_ack_i
);

   localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;
   typedef enum logic {OWN_INSTR, OWN_DATA} owner_t;

   state_t             state, state_next;
   owner_t             owner, last_owner;
   logic [CNT_W-1:0]   cnt;
   logic               instr_win, data_win, timeout_hit;

   // On a tie the port that did not own the previous transaction wins.
   assign instr_win   = instr_req_i && (!data_req_i || last_owner == OWN_DATA);
   assign data_win    = data_req_i && (!instr_req_i || last_owner == OWN_INSTR);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TO_LAST));

   always_comb begin
      state_next  = state;
      instr_gnt_o = 1'b0;
      data_gnt_o  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rst_core) begin
               instr_gnt_o = instr_win;
               data_gnt_o  = data_win;
            end
            if (instr_win || data_win) state_next = S_BUS;
         end
         S_BUS: begin
            if (wb_ack_i || timeout_hit) state_next = S_RESP;
         end
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_core) begin
      if (rst_core) state <= S_IDLE;
      else          state <= state_next;
   end

   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         owner          <= OWN_INSTR;
         last_owner     <= OWN_INSTR;
         cnt            <= '0;
         wb_cyc_o       <= 1'b0;
         wb_stb_o       <= 1'b0;
         wb_we_o        <= 1'b0;
         wb_sel_o       <= '0;
         wb_addr_o      <= '0;
         wb_data_o      <= '0;
         instr_rvalid_o <= 1'b0;
         instr_rdata_o  <= '0;
         instr_err_o    <= 1'b0;
         data_rvalid_o  <= 1'b0;
         data_rdata_o   <= '0;
         data_err_o     <= 1'b0;
      end else begin
         instr_rvalid_o <= 1'b0;
         instr_err_o    <= 1'b0;
         data_rvalid_o  <= 1'b0;
         data_err_o     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (instr_gnt_o) begin
                  owner      <= OWN_INSTR;
                  last_owner <= OWN_INSTR;
                  wb_addr_o  <= instr_addr_i;
                  wb_we_o    <= 1'b0;
                  wb_sel_o   <= '1;
                  wb_data_o  <= '0;
                  wb_cyc_o   <= 1'b1;
                  wb_stb_o   <= 1'b1;
                  cnt        <= '0;
               end else if (data_gnt_o) begin
                  owner      <= OWN_DATA;
                  last_owner <= OWN_DATA;
                  wb_addr_o  <= data_addr_i;
                  wb_we_o    <= data_we_i;
                  wb_sel_o   <= data_be_i;
                  wb_data_o  <= data_wdata_i;
                  wb_cyc_o   <= 1'b1;
                  wb_stb_o   <= 1'b1;
                  cnt        <= '0;
               end
            end
            S_BUS: begin
               cnt <= cnt + 1'b1;
               // Ack takes priority over a timeout landing in the same cycle.
               if (wb_ack_i) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  if (owner == OWN_INSTR) begin
                     instr_rvalid_o <= 1'b1;
                     instr_rdata_o  <= wb_data_i;
                  end else begin
                     data_rvalid_o  <= 1'b1;
                     data_rdata_o   <= wb_data_i;
                  end
               end else if (timeout_hit) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  if (owner == OWN_INSTR) begin
                     instr_rvalid_o <= 1'b1;
                     instr_err_o    <= 1'b1;
                     instr_rdata_o  <= '0;
                  end else begin
                     data_rvalid_o  <= 1'b1;
                     data_err_o     <= 1'b1;
                     data_rdata_o   <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_obi_wb_arbiter.sv
// Directed bench for obi_wb_arbiter: single-port reads/writes, round-robin
// ties, timeout abort, ack/timeout race, mid-transaction reset.
module tb_obi_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_gnt, instr_rvalid, instr_err;
   logic [31:0] instr_rdata;
   logic        data_req, data_we;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata;
   logic        data_gnt, data_rvalid, data_err;
   logic [31:0] data_rdata;
   logic        wb_cyc, wb_stb, wb_we, wb_ack;
   logic [3:0]  wb_sel;
   logic [31:0] wb_addr, wb_wdata, wb_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   obi_wb_arbiter #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_core      (clk),
      .rst_core      (rst),
      .instr_req_i   (instr_req),
      .instr_addr_i  (instr_addr),
      .instr_gnt_o   (instr_gnt),
      .instr_rvalid_o(instr_rvalid),
      .instr_rdata_o (instr_rdata),
      .instr_err_o   (instr_err),
      .data_req_i    (data_req),
      .data_we_i     (data_we),
      .data_be_i     (data_be),
      .data_addr_i   (data_addr),
      .data_wdata_i  (data_wdata),
      .data_gnt_o    (data_gnt),
      .data_rvalid_o (data_rvalid),
      .data_rdata_o  (data_rdata),
      .data_err_o    (data_err),
      .wb_cyc_o      (wb_cyc),
      .wb_stb_o      (wb_stb),
      .wb_we_o       (wb_we),
      .wb_sel_o      (wb_sel),
      .wb_addr_o     (wb_addr),
      .wb_data_o     (wb_wdata),
      .wb_data_i     (wb_rdata),
      .wb_ack_i      (wb_ack)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Starts in BUS cycle 1; checks held fields every BUS cycle and optionally
   // acks on cycle n. Returns positioned in the cycle after the n-th BUS cycle.
   task automatic bus_phase(input string tag, input int n, input logic ack_last,
                            input logic [31:0] rd, input logic [31:0] ea,
                            input logic ewe, input logic [3:0] esel,
                            input logic [31:0] ewd);
      for (int i = 1; i <= n; i++) begin
         check({tag, "_cyc"},  wb_cyc, 1'b1);
         check({tag, "_stb"},  wb_stb, 1'b1);
         check({tag, "_addr"}, wb_addr, ea);
         check({tag, "_we"},   wb_we, ewe);
         check({tag, "_sel"},  wb_sel, esel);
         check({tag, "_wdat"}, wb_wdata, ewd);
         check({tag, "_gnt"},  {instr_gnt, data_gnt}, 2'b00);
         if (i == n && ack_last) begin
            wb_ack   = 1'b1;
            wb_rdata = rd;
         end
         tick();
         wb_ack = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      instr_req = 1'b1; instr_addr = 32'h0;
      data_req = 1'b1; data_we = 1'b0; data_be = 4'h0;
      data_addr = 32'h0; data_wdata = 32'h0;
      wb_ack = 1'b0; wb_rdata = 32'h0;
      tick();
      tick();
      check("rst_gnt", {instr_gnt, data_gnt}, 2'b00);
      check("rst_cyc", {wb_cyc, wb_stb, wb_we}, 3'b000);
      check("rst_sel", wb_sel, 4'h0);
      check("rst_addr", wb_addr, 32'h0);
      check("rst_wdat", wb_wdata, 32'h0);
      check("rst_rv", {instr_rvalid, instr_err, data_rvalid, data_err}, 4'b0000);
      check("rst_rdat", {instr_rdata, data_rdata}, 64'h0);

      // 1: instruction fetch, ack on second stb cycle
      rst = 1'b0; data_req = 1'b0;
      instr_addr = 32'h100;
      #1;
      check("t1_igrant", {instr_gnt, data_gnt}, 2'b10);
      tick();
      instr_req = 1'b0;
      bus_phase("t1", 2, 1'b1, 32'h0000_0013, 32'h100, 1'b0, 4'hF, 32'h0);
      check("t1_irv", {instr_rvalid, instr_err}, 2'b10);
      check("t1_irdata", instr_rdata, 32'h0000_0013);
      check("t1_drv", data_rvalid, 1'b0);
      check("t1_cycdrop", {wb_cyc, wb_stb}, 2'b00);
      tick();
      check("t1_irv_clr", instr_rvalid, 1'b0);
      check("t1_irdata_hold", instr_rdata, 32'h0000_0013);

      // 2: data write, ack on third stb cycle; instr request during BUS waits
      data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
      data_addr = 32'h2004; data_wdata = 32'hDEAD_BEEF;
      #1;
      check("t2_dgrant", {instr_gnt, data_gnt}, 2'b01);
      tick();
      data_req = 1'b0;
      instr_req = 1'b1; instr_addr = 32'h200;
      bus_phase("t2", 3, 1'b1, 32'h0BAD_F00D, 32'h2004, 1'b1, 4'b0011, 32'hDEAD_BEEF);
      check("t2_drv", {data_rvalid, data_err}, 2'b10);
      check("t2_irv", instr_rvalid, 1'b0);
      check("t2_resp_gnt", {instr_gnt, data_gnt}, 2'b00);
      instr_req = 1'b0;
      tick();
      check("t2_drv_clr", data_rvalid, 1'b0);
      check("t2_idle_cyc", wb_cyc, 1'b0);

      // 3: both requesting continuously from reset -> D, I, D, I
      rst = 1'b1;
      instr_req = 1'b1; instr_addr = 32'h300;
      data_req = 1'b1; data_we = 1'b0; data_be = 4'hF;
      data_addr = 32'h400; data_wdata = 32'h55;
      tick();
      rst = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         logic is_data;
         is_data = (k % 2 == 0);
         check("t3_gnt", {instr_gnt, data_gnt}, is_data ? 2'b01 : 2'b10);
         tick();
         if (is_data)
            bus_phase("t3d", 1, 1'b1, 32'h1000 + k, 32'h400, 1'b0, 4'hF, 32'h55);
         else
            bus_phase("t3i", 1, 1'b1, 32'h1000 + k, 32'h300, 1'b0, 4'hF, 32'h0);
         check("t3_rv", {instr_rvalid, data_rvalid}, is_data ? 2'b01 : 2'b10);
         check("t3_rdata", is_data ? data_rdata : instr_rdata, 32'h1000 + k);
         tick();
      end
      instr_req = 1'b0; data_req = 1'b0;

      // 4: data read never acked -> timeout after 8 BUS cycles
      wb_rdata = 32'hFFFF_FFFF;
      data_req = 1'b1; data_addr = 32'h500;
      #1;
      check("t4_dgrant", {instr_gnt, data_gnt}, 2'b01);
      tick();
      data_req = 1'b0;
      bus_phase("t4", 8, 1'b0, 32'h0, 32'h500, 1'b0, 4'hF, 32'h55);
      check("t4_cycdrop", {wb_cyc, wb_stb}, 2'b00);
      check("t4_drv", {data_rvalid, data_err}, 2'b11);
      check("t4_drdata", data_rdata, 32'h0);
      check("t4_irv", instr_rvalid, 1'b0);
      instr_req = 1'b1; instr_addr = 32'h600;
      tick();
      check("t4_after_gnt", {instr_gnt, data_gnt}, 2'b10);
      check("t4_err_clr", {data_rvalid, data_err}, 2'b00);
      tick();
      instr_req = 1'b0;
      bus_phase("t4i", 1, 1'b1, 32'h77, 32'h600, 1'b0, 4'hF, 32'h0);
      check("t4i_rv", {instr_rvalid, instr_err}, 2'b10);
      check("t4i_rdata", instr_rdata, 32'h77);
      tick();

      // 5: ack on the 8th BUS cycle beats the timeout
      data_req = 1'b1; data_addr = 32'h700;
      #1;
      check("t5_dgrant", {instr_gnt, data_gnt}, 2'b01);
      tick();
      data_req = 1'b0;
      bus_phase("t5", 8, 1'b1, 32'hCAFE_F00D, 32'h700, 1'b0, 4'hF, 32'h55);
      check("t5_drv", {data_rvalid, data_err}, 2'b10);
      check("t5_drdata", data_rdata, 32'hCAFE_F00D);
      tick();

      // 6: reset mid-transaction, spurious ack, then tie goes to data
      instr_req = 1'b1; instr_addr = 32'h800;
      #1;
      check("t6_igrant", {instr_gnt, data_gnt}, 2'b10);
      tick();
      instr_req = 1'b0;
      check("t6_bus_cyc", wb_cyc, 1'b1);
      rst = 1'b1;
      tick();
      check("t6_rst_cyc", {wb_cyc, wb_stb}, 2'b00);
      check("t6_rst_rv", {instr_rvalid, data_rvalid}, 2'b00);
      rst = 1'b0;
      tick();
      check("t6_post_rv", {instr_rvalid, data_rvalid}, 2'b00);
      wb_ack = 1'b1; wb_rdata = 32'h99;
      tick();
      wb_ack = 1'b0;
      check("t6_spur_rv", {instr_rvalid, data_rvalid}, 2'b00);
      check("t6_spur_cyc", wb_cyc, 1'b0);
      tick();
      check("t6_spur_rv2", {instr_rvalid, data_rvalid}, 2'b00);
      instr_req = 1'b1; data_req = 1'b1; data_addr = 32'h900;
      #1;
      check("t6_tie", {instr_gnt, data_gnt}, 2'b01);
      tick();
      instr_req = 1'b0; data_req = 1'b0;
      bus_phase("t6", 1, 1'b1, 32'h1234, 32'h900, 1'b0, 4'hF, 32'h55);
      check("t6_drv", {data_rvalid, instr_rvalid}, 2'b10);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
